// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the instruction in D into ALU/control fields, registers
// them into the D/E pipeline register, and handles load-use stalls and E-stage flushes.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    input  logic        valid_d,
    input  logic        flush_e,
    output logic [4:0]  alu_op_e,
    output logic        alu_en_e,
    output logic [31:0] imm_e,
    output logic        alusrc_imm_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic        reg_write_e,
    output logic        mem_read_e,
    output logic        mem_write_e,
    output logic [31:0] pc_e,
    output logic        valid_e,
    output logic        illegal_e,
    output logic        stall_d
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned OPW  = 5;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [OPW-1:0]  alu_op;
        logic            alu_en;
        logic [XLEN-1:0] imm;
        logic            alusrc_imm;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [XLEN-1:0] pc;
    } de_t;

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LUI = 7'b0110111,
                           OPC_LD = 7'b0000011, OPC_ST = 7'b0100011, OPC_BR = 7'b1100011,
                           OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
    localparam logic [6:0] F7_0 = 7'b0000000, F7_ALT = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_sh, imm_lui, imm_u;
    logic            legal, wr_rd;
    de_t             dec, e_d, e_q;

    assign opcode  = instr_d[6:0];
    assign f3      = instr_d[14:12];
    assign f7      = instr_d[31:25];
    assign imm_i   = {{20{instr_d[31]}}, instr_d[31:20]};
    assign imm_s   = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
    assign imm_b   = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
    assign imm_j   = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
    assign imm_sh  = {27'b0, instr_d[24:20]};
    assign imm_lui = {12'b0, instr_d[31:12]};
    assign imm_u   = {instr_d[31:12], 12'b0};

    // Instruction decode; unused register fields are forced to zero
    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        wr_rd      = 1'b0;
        dec.valid  = 1'b1;
        dec.pc     = pc_d;
        dec.rs1    = instr_d[19:15];
        dec.rs2    = instr_d[24:20];
        dec.rd     = instr_d[11:7];
        unique case (opcode)
            OPC_R: begin
                wr_rd = 1'b1;
                unique case ({f7, f3})
                    {F7_0, 3'b000}:   dec.alu_op = 5'd1;
                    {F7_ALT, 3'b000}: dec.alu_op = 5'd2;
                    {F7_0, 3'b111}:   dec.alu_op = 5'd3;
                    {F7_0, 3'b110}:   dec.alu_op = 5'd4;
                    {F7_0, 3'b100}:   dec.alu_op = 5'd5;
                    {F7_0, 3'b010}:   dec.alu_op = 5'd6;
                    {F7_0, 3'b011}:   dec.alu_op = 5'd7;
                    {F7_ALT, 3'b101}: dec.alu_op = 5'd8;
                    {F7_0, 3'b101}:   dec.alu_op = 5'd9;
                    {F7_0, 3'b001}:   dec.alu_op = 5'd10;
                    default:          legal = 1'b0;
                endcase
            end
            OPC_I: begin
                wr_rd          = 1'b1;
                dec.rs2        = '0;
                dec.alusrc_imm = 1'b1;
                dec.imm        = imm_i;
                unique case (f3)
                    3'b000: dec.alu_op = 5'd11;
                    3'b111: dec.alu_op = 5'd12;
                    3'b110: dec.alu_op = 5'd13;
                    3'b100: dec.alu_op = 5'd14;
                    3'b010: dec.alu_op = 5'd15;
                    3'b011: dec.alu_op = 5'd16;
                    3'b101: begin
                        dec.imm = imm_sh;
                        if (f7 == F7_ALT)    dec.alu_op = 5'd17;
                        else if (f7 == F7_0) dec.alu_op = 5'd18;
                        else                 legal = 1'b0;
                    end
                    default: begin
                        dec.imm    = imm_sh;
                        dec.alu_op = 5'd19;
                        legal      = (f7 == F7_0);
                    end
                endcase
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                wr_rd          = 1'b1;
                dec.rs1        = '0;
                dec.rs2        = '0;
                dec.alusrc_imm = 1'b1;
                if (opcode == OPC_LUI) begin
                    dec.alu_op = 5'd20;
                    dec.imm    = imm_lui;
                end else if (opcode == OPC_AUIPC) begin
                    dec.alu_op = 5'd29;
                    dec.imm    = imm_u;
                end else begin
                    dec.alu_op = 5'd30;
                    dec.imm    = imm_j;
                end
            end
            OPC_JALR: begin
                wr_rd          = 1'b1;
                dec.rs2        = '0;
                dec.alusrc_imm = 1'b1;
                dec.imm        = imm_i;
                dec.alu_op     = 5'd31;
                legal          = (f3 == 3'b000);
            end
            OPC_LD: begin
                wr_rd          = 1'b1;
                dec.rs2        = '0;
                dec.alusrc_imm = 1'b1;
                dec.imm        = imm_i;
                dec.mem_read   = 1'b1;
                dec.alu_op     = 5'd21;
                legal          = (f3 == 3'b010);
            end
            OPC_ST: begin
                dec.rd         = '0;
                dec.alusrc_imm = 1'b1;
                dec.imm        = imm_s;
                dec.mem_write  = 1'b1;
                dec.alu_op     = 5'd22;
                legal          = (f3 == 3'b010);
            end
            OPC_BR: begin
                dec.rd  = '0;
                dec.imm = imm_b;
                unique case (f3)
                    3'b000:  dec.alu_op = 5'd23;
                    3'b001:  dec.alu_op = 5'd24;
                    3'b100:  dec.alu_op = 5'd25;
                    3'b101:  dec.alu_op = 5'd26;
                    3'b110:  dec.alu_op = 5'd27;
                    3'b111:  dec.alu_op = 5'd28;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        dec.alu_en    = 1'b1;
        dec.reg_write = wr_rd && (dec.rd != '0);
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec.pc      = pc_d;
        end
    end

    // Load-use hazard: unused source fields are zero, so rd_e != 0 excludes them
    assign stall_d = valid_d && e_q.valid && e_q.mem_read && (e_q.rd != '0) &&
                     ((dec.rs1 == e_q.rd) || (dec.rs2 == e_q.rd));

    assign e_d = (flush_e || stall_d || !valid_d) ? de_t'('0) : dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= '0;
        else        e_q <= e_d;
    end

    assign alu_op_e     = e_q.alu_op;
    assign alu_en_e     = e_q.alu_en;
    assign imm_e        = e_q.imm;
    assign alusrc_imm_e = e_q.alusrc_imm;
    assign rs1_e        = e_q.rs1;
    assign rs2_e        = e_q.rs2;
    assign rd_e         = e_q.rd;
    assign reg_write_e  = e_q.reg_write;
    assign mem_read_e   = e_q.mem_read;
    assign mem_write_e  = e_q.mem_write;
    assign pc_e         = e_q.pc;
    assign valid_e      = e_q.valid;
    assign illegal_e    = e_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed decode results, load-use stall,
// flush priority, illegal encodings and asynchronous reset.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d, pc_d;
    logic        valid_d, flush_e;
    logic [4:0]  alu_op_e, rs1_e, rs2_e, rd_e;
    logic        alu_en_e, alusrc_imm_e, reg_write_e, mem_read_e, mem_write_e;
    logic        valid_e, illegal_e, stall_d;
    logic [31:0] imm_e, pc_e;
    int          total = 0;
    int          bad = 0;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
        .flush_e(flush_e), .alu_op_e(alu_op_e), .alu_en_e(alu_en_e), .imm_e(imm_e),
        .alusrc_imm_e(alusrc_imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .pc_e(pc_e), .valid_e(valid_e), .illegal_e(illegal_e), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_e(input string tag, input logic [4:0] op, input logic en,
                           input logic [31:0] imm, input logic src, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                           input logic mr, input logic mw, input logic [31:0] pc,
                           input logic v, input logic ill);
        chk({tag, ".alu_op"}, 32'(alu_op_e), 32'(op));
        chk({tag, ".alu_en"}, 32'(alu_en_e), 32'(en));
        chk({tag, ".imm"}, imm_e, imm);
        chk({tag, ".alusrc"}, 32'(alusrc_imm_e), 32'(src));
        chk({tag, ".rs1"}, 32'(rs1_e), 32'(r1));
        chk({tag, ".rs2"}, 32'(rs2_e), 32'(r2));
        chk({tag, ".rd"}, 32'(rd_e), 32'(rd));
        chk({tag, ".reg_write"}, 32'(reg_write_e), 32'(rw));
        chk({tag, ".mem_read"}, 32'(mem_read_e), 32'(mr));
        chk({tag, ".mem_write"}, 32'(mem_write_e), 32'(mw));
        chk({tag, ".pc"}, pc_e, pc);
        chk({tag, ".valid"}, 32'(valid_e), 32'(v));
        chk({tag, ".illegal"}, 32'(illegal_e), 32'(ill));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        instr_d = ins;
        pc_d    = pc;
        valid_d = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush_e = 1'b0;
        drive(32'h002081B3, 32'h100, 1'b1);
        #1;
        check_e("reset", 5'd0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);
        chk("reset.stall", 32'(stall_d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tick();
        check_e("add", 5'd1, 1, 32'h0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 32'h100, 1, 0);
        drive(32'h402081B3, 32'h104, 1'b1);
        tick();
        check_e("sub", 5'd2, 1, 32'h0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 32'h104, 1, 0);
        drive(32'hFFF00093, 32'h108, 1'b1);
        tick();
        check_e("addi", 5'd11, 1, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd1, 1, 0, 0, 32'h108, 1, 0);
        drive(32'h123453B7, 32'h10C, 1'b1);
        tick();
        check_e("lui", 5'd20, 1, 32'h00012345, 1, 5'd0, 5'd0, 5'd7, 1, 0, 0, 32'h10C, 1, 0);
        drive(32'hFE208CE3, 32'h110, 1'b1);
        tick();
        check_e("beq", 5'd23, 1, 32'hFFFFFFF8, 0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 32'h110, 1, 0);
        drive(32'h0020A223, 32'h114, 1'b1);
        tick();
        check_e("sw", 5'd22, 1, 32'h4, 1, 5'd1, 5'd2, 5'd0, 0, 0, 1, 32'h114, 1, 0);
        drive(32'h40325213, 32'h118, 1'b1);
        tick();
        check_e("srai", 5'd17, 1, 32'h3, 1, 5'd4, 5'd0, 5'd4, 1, 0, 0, 32'h118, 1, 0);

        // load-use: LW x5 then ADD x6,x5,x0
        drive(32'h0080A283, 32'h200, 1'b1);
        tick();
        check_e("lw", 5'd21, 1, 32'h8, 1, 5'd1, 5'd0, 5'd5, 1, 1, 0, 32'h200, 1, 0);
        drive(32'h00028333, 32'h204, 1'b1);
        #1;
        chk("lu.stall", 32'(stall_d), 32'd1);
        tick();
        check_e("lu.bubble", 5'd0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);
        chk("lu.stall_drop", 32'(stall_d), 32'd0);
        tick();
        check_e("lu.add", 5'd1, 1, 32'h0, 0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 32'h204, 1, 0);
        chk("lu.no_stall", 32'(stall_d), 32'd0);

        // flush overrides stall
        drive(32'h0080A283, 32'h300, 1'b1);
        tick();
        drive(32'h00028333, 32'h304, 1'b1);
        flush_e = 1'b1;
        #1;
        chk("fl.stall", 32'(stall_d), 32'd1);
        tick();
        flush_e = 1'b0;
        check_e("fl.bubble", 5'd0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        check_e("fl.add", 5'd1, 1, 32'h0, 0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 32'h304, 1, 0);

        // illegal encodings and invalid D
        drive(32'h00000000, 32'h400, 1'b1);
        tick();
        check_e("ill0", 5'd0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h400, 1, 1);
        drive(32'h00008083, 32'h404, 1'b1);
        tick();
        check_e("lb", 5'd0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h404, 1, 1);
        drive(32'h002081B3, 32'h408, 1'b0);
        tick();
        check_e("vd0", 5'd0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);

        // async reset mid-stream, then normal load after release
        drive(32'h0080A283, 32'h500, 1'b1);
        tick();
        check_e("pre_rst", 5'd21, 1, 32'h8, 1, 5'd1, 5'd0, 5'd5, 1, 1, 0, 32'h500, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_e("mid_rst", 5'd0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);
        chk("mid_rst.stall", 32'(stall_d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h002081B3, 32'h600, 1'b1);
        tick();
        check_e("post_rst", 5'd1, 1, 32'h0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 32'h600, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I pipeline: decodes the 32-bit instruction in D into the 5-bit ALU operation code, enable, immediate and register/control fields consumed by the execute-stage ALU, and registers them into the D/E pipeline register. It also detects load-use hazards (stall D, bubble E) and applies execute-stage branch flushes.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_d  in  32  instruction in decode
- pc_d  in  32  PC of instr_d
- valid_d  in  1  instr_d is a real instruction
- flush_e  in  1  branch/jump taken in E; kill instruction entering E
- alu_op_e  out  5  ALU operation code (encoding below)
- alu_en_e  out  1  ALU operation valid
- imm_e  out  32  decoded immediate
- alusrc_imm_e  out  1  ALU operand 2 = imm_e (1) / rs2 data (0)
- rs1_e, rs2_e, rd_e  out  5 each  register addresses
- reg_write_e, mem_read_e, mem_write_e  out  1 each  write-back / load / store controls
- pc_e  out  32  PC of instruction in E
- valid_e  out  1  E holds a real instruction
- illegal_e  out  1  E holds an undecodable instruction
- stall_d  out  1  combinational; hold fetch/decode this cycle

## Operation
- Op codes (opcode/funct3/funct7): R-type 0110011: ADD 1, SUB 2 (f7 0100000), AND 3, OR 4, XOR 5, SLT 6, SLTU 7, SRA 8 (f7 0100000), SRL 9, SLL 10. I-ALU 0010011: ADDI 11, ANDI 12, ORI 13, XORI 14, SLTI 15, SLTIU 16, SRAI 17, SRLI 18, SLLI 19. LUI 0110111: 20. LW (0000011, f3 010): 21. SW (0100011, f3 010): 22. Branch 1100011: BEQ 23, BNE 24, BLT 25, BGE 26, BLTU 27, BGEU 28. AUIPC 29, JAL 30, JALR (f3 000) 31.
- Any other encoding (incl. byte/half loads/stores, bad funct7): alu_op 0, alu_en 0, all writes 0, illegal_e 1. FENCE/ECALL/EBREAK treated as illegal.
- Immediates: I-type/LW/JALR sign-extended instr[31:20]; shifts zero-extended instr[24:20]; SW sign-extended S-imm; branches sign-extended B-imm (bit 0 = 0); JAL sign-extended J-imm; LUI {12'b0, instr[31:12]} (ALU applies <<12); AUIPC {instr[31:12], 12'b0}.
- alusrc_imm_e 1 for I-ALU, LUI, LW, SW, AUIPC, JAL, JALR; 0 for R-type and branches.
- reg_write_e 1 for R, I-ALU, LUI, LW, AUIPC, JAL, JALR only when rd != 0. rd_e forced 0 for SW/branches; rs2_e forced 0 when rs2 unused; rs1_e forced 0 for LUI/AUIPC/JAL.
- Load-use hazard: stall_d = valid_d & valid_e & mem_read_e & rd_e != 0 & (rd_e == rs1 used by D or rd_e == rs2 used by D). On stall, E loads a bubble; D contents held externally.
- Bubble = valid_e 0, alu_op 0, alu_en 0, illegal 0, all control 0; addresses/imm/pc 0.
- valid_d 0 -> bubble into E.

## Timing
- Reset (async, rst_n low): every registered output 0; stall_d 0 (since valid_e 0).
- Latency: instr_d at edge N appears on *_e outputs after edge N+1; one cycle.
- Priority per edge: flush_e > stall_d > load decoded instruction. flush_e with stall_d -> bubble, stall_d ignored.
- Stall lasts exactly one cycle: after bubble, mem_read_e 0 so stall_d drops; the held instruction then enters E.
- Reset deasserted mid-stream: first edge after release loads normally from D.

## Test plan
- Reset then ADD x3,x1,x2 (0x002081B3), valid_d 1 -> next cycle alu_op_e 1, alu_en_e 1, rs1 1, rs2 2, rd 3, reg_write 1, alusrc 0; SUB 0x402081B3 -> alu_op 2.
- ADDI x1,x0,-1 (0xFFF00093) -> alu_op 11, imm_e 0xFFFFFFFF, alusrc 1; LUI x7,0x12345 (0x123453B7) -> alu_op 20, imm_e 0x00012345.
- BEQ x1,x2,-8 (0xFE208CE3) -> alu_op 23, imm_e 0xFFFFFFF8, reg_write 0, rd_e 0.
- LW x5,8(x1) (0x0080A283) then ADD x6,x5,x0 (0x00028333) -> alu_op 21, imm 8, mem_read 1; stall_d 1 one cycle, bubble in E, then alu_op 1 rd 6.
- flush_e 1 while stall_d 1 and valid ADD in D -> valid_e 0, all controls 0 next cycle.
- Illegal 0x00000000 and LB (0x00008083) -> illegal_e 1, alu_op 0, alu_en 0; rst_n low mid-stream -> all outputs 0 immediately, no clock.
